// File: rtl/regfile_pkg.sv
// Shared constants for the register-file sequencer.
// Macro command codes, micro-op encodings, FSM states and lengths.
package regfile_pkg;

    localparam logic [2:0] MC_NOP   = 3'd0;
    localparam logic [2:0] MC_LDA   = 3'd1;
    localparam logic [2:0] MC_LDB   = 3'd2;
    localparam logic [2:0] MC_LDOP  = 3'd3;
    localparam logic [2:0] MC_MOVAB = 3'd4;
    localparam logic [2:0] MC_SWAP  = 3'd5;
    localparam logic [2:0] MC_CLR   = 3'd6;
    localparam logic [2:0] MC_LDAB  = 3'd7;

    localparam logic [3:0] UOP_NOP     = 4'h0;
    localparam logic [3:0] UOP_WA_IMM  = 4'h1;
    localparam logic [3:0] UOP_WB_IMM  = 4'h2;
    localparam logic [3:0] UOP_WOP_IMM = 4'h3;
    localparam logic [3:0] UOP_A2B     = 4'h4;
    localparam logic [3:0] UOP_B2A     = 4'h5;
    localparam logic [3:0] UOP_A2OP    = 4'h6;
    localparam logic [3:0] UOP_OP2A    = 4'h7;
    localparam logic [3:0] UOP_B2OP    = 4'h8;
    localparam logic [3:0] UOP_OP2B    = 4'h9;
    localparam logic [3:0] UOP_LRST    = 4'hF;

    localparam logic [1:0] LEN_ONE  = 2'd1;
    localparam logic [1:0] LEN_LDAB = 2'd2;
    localparam logic [1:0] LEN_SWAP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_ABORT = 2'd2
    } state_e;

    function automatic logic [1:0] cmd_len(input logic [2:0] c);
        if (c == MC_SWAP)
            return LEN_SWAP;
        else if (c == MC_LDAB)
            return LEN_LDAB;
        else
            return LEN_ONE;
    endfunction

endpackage

// File: rtl/regfile_uop_rom.sv
// Combinational micro-op table: (command, step) -> micro-op.
// Also flags whether the step is the command's final one.
module regfile_uop_rom
    import regfile_pkg::*;
(
    input  logic [2:0] cmd,
    input  logic [1:0] step,
    output logic [3:0] uop,
    output logic       last
);

    // table lookup; out-of-range steps read as NOP
    always_comb begin
        uop  = UOP_NOP;
        last = (step == (cmd_len(cmd) - 2'd1));
        unique case (cmd)
            MC_LDA:   if (step == 2'd0) uop = UOP_WA_IMM;
            MC_LDB:   if (step == 2'd0) uop = UOP_WB_IMM;
            MC_LDOP:  if (step == 2'd0) uop = UOP_WOP_IMM;
            MC_MOVAB: if (step == 2'd0) uop = UOP_A2B;
            MC_CLR:   if (step == 2'd0) uop = UOP_LRST;
            MC_SWAP: begin
                unique case (step)
                    2'd0:    uop = UOP_A2OP;
                    2'd1:    uop = UOP_B2A;
                    2'd2:    uop = UOP_OP2B;
                    default: uop = UOP_NOP;
                endcase
            end
            MC_LDAB: begin
                unique case (step)
                    2'd0:    uop = UOP_WA_IMM;
                    2'd1:    uop = UOP_WB_IMM;
                    default: uop = UOP_NOP;
                endcase
            end
            default: uop = UOP_NOP;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Expands macro commands into register-file micro-ops, one per cycle.
// step holds the index of the micro-op most recently issued.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int IMM_W   = 4,
    parameter int INSTR_W = 4
) (
    input  logic               clk,
    input  logic               grst,
    input  logic [2:0]         cmd,
    input  logic [IMM_W-1:0]   cmd_imm,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               stall,
    input  logic               abort,
    output logic [INSTR_W-1:0] instr,
    output logic [IMM_W-1:0]   imm,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_n;
    logic [1:0]         step_q, step_n;
    logic [2:0]         cmd_q, cmd_n;
    logic [INSTR_W-1:0] instr_n;
    logic [IMM_W-1:0]   imm_n;
    logic               busy_n, done_n;
    logic               accept;
    logic [2:0]         rom_cmd;
    logic [1:0]         rom_step;
    logic [3:0]         rom_uop;
    logic               rom_last;

    assign cmd_ready = (state_q == S_IDLE) && !stall;
    assign accept    = cmd_valid && cmd_ready;
    assign rom_cmd   = (state_q == S_IDLE) ? cmd : cmd_q;
    assign rom_step  = (state_q == S_IDLE) ? 2'd0 : step_q + 2'd1;

    regfile_uop_rom u_rom (
        .cmd  (rom_cmd),
        .step (rom_step),
        .uop  (rom_uop),
        .last (rom_last)
    );

    // next state and next registered outputs
    always_comb begin
        state_n = state_q;
        step_n  = step_q;
        cmd_n   = cmd_q;
        imm_n   = imm;
        instr_n = INSTR_W'(UOP_NOP);
        busy_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                imm_n = '0;
                if (accept) begin
                    state_n = S_EXEC;
                    step_n  = 2'd0;
                    cmd_n   = cmd;
                    imm_n   = cmd_imm;
                    instr_n = INSTR_W'(rom_uop);
                    busy_n  = 1'b1;
                    done_n  = rom_last;
                end
            end
            S_EXEC: begin
                if (done) begin
                    state_n = S_IDLE;
                    imm_n   = '0;
                end else if (abort) begin
                    state_n = S_ABORT;
                    instr_n = INSTR_W'(UOP_LRST);
                    busy_n  = 1'b1;
                end else if (stall) begin
                    busy_n  = 1'b1;
                end else begin
                    step_n  = rom_step;
                    instr_n = INSTR_W'(rom_uop);
                    busy_n  = 1'b1;
                    done_n  = rom_last;
                end
            end
            S_ABORT: begin
                state_n = S_IDLE;
                imm_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                imm_n   = '0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            cmd_q   <= 3'd0;
            instr   <= '0;
            imm     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            step_q  <= step_n;
            cmd_q   <= cmd_n;
            instr   <= instr_n;
            imm     <= imm_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer.
// Model keeps a queue of pending micro-ops per command.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       grst = 1'b0;
    logic [2:0] cmd = '0;
    logic [3:0] cmd_imm = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       stall = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] instr;
    logic [3:0] imm;
    logic       busy;
    logic       done;

    regfile_sequencer #(.IMM_W(4), .INSTR_W(4)) dut (
        .clk       (clk),
        .grst      (grst),
        .cmd       (cmd),
        .cmd_imm   (cmd_imm),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .stall     (stall),
        .abort     (abort),
        .instr     (instr),
        .imm       (imm),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  instr;
        logic [3:0]  imm;
        logic        busy;
        logic        done;
        logic        ready;
        logic [11:0] regs;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   ntests = 0;
    int   nfail = 0;
    int   dut_dones = 0;
    int   mdl_dones = 0;
    bit   run = 0;

    // model state: phase 0 idle, 1 running, 2 abort cycle
    int         phase = 0;
    logic [3:0] rem[$];
    logic [3:0] m_instr = '0;
    logic [3:0] m_imm = '0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [11:0] m_regs = '0;
    logic [11:0] d_regs = '0;

    // register-file behaviour {A,B,OP}
    function automatic logic [11:0] rf_apply(input logic [3:0] u,
                                             input logic [3:0] v,
                                             input logic [11:0] r);
        logic [3:0] a, b, o;
        a = r[11:8]; b = r[7:4]; o = r[3:0];
        case (u)
            4'h1: a = v;
            4'h2: b = v;
            4'h3: o = v;
            4'h4: b = a;
            4'h5: a = b;
            4'h6: o = a;
            4'h7: a = o;
            4'h8: o = b;
            4'h9: b = o;
            4'hF: begin a = 0; b = 0; o = 0; end
            default: ;
        endcase
        return {a, b, o};
    endfunction

    // register file fed by the DUT outputs
    always @(posedge clk) d_regs <= rf_apply(instr, imm, d_regs);

    task automatic load_cmd(input logic [2:0] c);
        rem.delete();
        case (c)
            3'd0: rem.push_back(4'h0);
            3'd1: rem.push_back(4'h1);
            3'd2: rem.push_back(4'h2);
            3'd3: rem.push_back(4'h3);
            3'd4: rem.push_back(4'h4);
            3'd5: begin
                rem.push_back(4'h6);
                rem.push_back(4'h5);
                rem.push_back(4'h9);
            end
            3'd6: rem.push_back(4'hF);
            default: begin
                rem.push_back(4'h1);
                rem.push_back(4'h2);
            end
        endcase
    endtask

    task automatic m_idle();
        phase = 0;
        rem.delete();
        m_instr = 0; m_imm = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_edge();
        m_regs = rf_apply(m_instr, m_imm, m_regs);
        if (phase == 0) begin
            if (cmd_valid && !stall) begin
                load_cmd(cmd);
                m_instr = rem.pop_front();
                m_imm = cmd_imm;
                m_done = (rem.size() == 0);
                m_busy = 1;
                phase = 1;
            end else begin
                m_idle();
            end
        end else if (phase == 1) begin
            if (m_done) begin
                m_idle();
            end else if (abort) begin
                phase = 2;
                rem.delete();
                m_instr = 4'hF; m_done = 0;
            end else if (stall) begin
                m_instr = 0; m_done = 0;
            end else begin
                m_instr = rem.pop_front();
                m_done = (rem.size() == 0);
            end
        end else begin
            m_idle();
        end
    endtask

    task automatic tick();
        exp_t x;
        if (!grst) m_idle();
        x.instr = m_instr;
        x.imm   = m_imm;
        x.busy  = m_busy;
        x.done  = m_done;
        x.ready = (phase == 0) && !stall;
        x.regs  = m_regs;
        if (m_done) mdl_dones++;
        exp_q.push_back(x);
        @(posedge clk);
        if (grst) model_edge();
        #1;
    endtask

    task automatic go(input logic v, input logic [2:0] c,
                      input logic [3:0] i, input logic s,
                      input logic a);
        cmd_valid = v; cmd = c; cmd_imm = i; stall = s; abort = a;
        tick();
    endtask

    // monitor: compare DUT against the oldest expectation
    always @(negedge clk) begin
        if (run) begin
            ntests++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL sb_empty: got no expectation, want one");
            end else begin
                e = exp_q.pop_front();
                if ({instr, imm, busy, done, cmd_ready} !==
                    {e.instr, e.imm, e.busy, e.done, e.ready}) begin
                    nfail++;
                    $display("FAIL outputs @%0t: got i=%h m=%h b=%b d=%b r=%b want i=%h m=%h b=%b d=%b r=%b",
                             $time, instr, imm, busy, done, cmd_ready,
                             e.instr, e.imm, e.busy, e.done, e.ready);
                end
                ntests++;
                if (d_regs !== e.regs) begin
                    nfail++;
                    $display("FAIL regs @%0t: got %h want %h",
                             $time, d_regs, e.regs);
                end
            end
            if (done === 1'b1) dut_dones++;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        run = 1;
        // reset
        go(0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0);
        grst = 1'b1;
        go(0, 0, 0, 0, 0);
        // load A
        go(1, 3'd1, 4'hA, 0, 0);
        go(0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0);
        // A=3, B=5, swap
        go(1, 3'd1, 4'h3, 0, 0);
        go(0, 0, 0, 0, 0);
        go(1, 3'd2, 4'h5, 0, 0);
        go(0, 0, 0, 0, 0);
        go(1, 3'd5, 4'h0, 0, 0);
        repeat (4) go(0, 0, 0, 0, 0);
        // LDAB with a two-cycle stall
        go(1, 3'd7, 4'h7, 0, 0);
        go(0, 0, 0, 1, 0);
        go(0, 0, 0, 1, 0);
        go(0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0);
        // swap aborted on its second step
        go(1, 3'd5, 4'h2, 0, 0);
        go(0, 0, 0, 0, 1);
        go(0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0);
        // reset in the middle of a swap
        go(1, 3'd5, 4'h4, 0, 0);
        go(0, 0, 0, 0, 0);
        grst = 1'b0;
        go(0, 0, 0, 0, 0);
        grst = 1'b1;
        go(0, 0, 0, 0, 0);
        go(1, 3'd0, 4'h0, 0, 0);
        go(0, 0, 0, 0, 0);
        // back-to-back loads with cmd_valid held
        for (int k = 0; k < 12; k++)
            go(1, 3'd2, 4'($urandom_range(0, 15)), 0, 0);
        go(0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0);
        // random traffic
        for (int k = 0; k < 500; k++) begin
            if (!grst) grst = 1'b1;
            else if ($urandom_range(0, 99) == 0) grst = 1'b0;
            go(1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)),
               1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 9) == 0));
        end
        grst = 1'b1;
        repeat (5) go(0, 0, 0, 0, 0);
        run = 0;
        ntests++;
        if (dut_dones != mdl_dones) begin
            nfail++;
            $display("FAIL done_count: got %0d want %0d",
                     dut_dones, mdl_dones);
        end
        ntests++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL sb_leftover: got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Microcoded sequencer that drives the 4-bit processor's register file (A, B, OP registers on the shared 4-bit tristate bus).
- Accepts one macro command at a time from the control unit over a valid/ready handshake.
- Expands each command into a sequence of register-file micro-ops (instr) plus an immediate (imm), one per cycle.
- Sits between the top-level control FSM and the register file; it is the only driver of the register file's instr/imm inputs.

Parameters:
IMM_W, 4, immediate/data width (matches the bus width).
INSTR_W, 4, register-file micro-op width.

Ports:
clk  input  1  system clock, rising edge.
grst  input  1  global reset, asynchronous, active-low.
cmd  input  3  macro command code (MC_* constants).
cmd_imm  input  IMM_W  immediate operand for load commands.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
stall  input  1  freeze sequencing; forces NOP.
abort  input  1  synchronous abort of the current command.
instr  output  INSTR_W  registered micro-op to the register file.
imm  output  IMM_W  registered immediate to the register file.
busy  output  1  command in progress (EXEC or ABORT).
done  output  1  one-cycle pulse with the last micro-op of a command.

Behaviour:
- Reset (grst=0, asynchronous): state=IDLE, instr=UOP_NOP, imm=0, busy=0, done=0, step=0, latched cmd/imm=0. An in-flight command is dropped with no completion pulse.
- All outputs are registered. cmd_ready = (state==IDLE) && !stall.
- Handshake: cmd_valid && cmd_ready on edge N latches cmd and cmd_imm. The first micro-op is on instr in cycle N+1, with busy=1. cmd_valid while not ready is ignored; the requester holds it.
- Command table (step0, step1, step2):
  - MC_NOP: NOP.
  - MC_LDA: WA_IMM.
  - MC_LDB: WB_IMM.
  - MC_LDOP: WOP_IMM.
  - MC_MOVAB: A2B.
  - MC_SWAP: A2OP, B2A, OP2B.
  - MC_CLR: LRST.
  - MC_LDAB: WA_IMM, WB_IMM.
- Lengths: 1 step, except SWAP = 3 and LDAB = 2.
- imm output holds the latched cmd_imm for the whole command and is 0 in IDLE.
- FSM:
  - IDLE: on accept, go to EXEC with step=0.
  - EXEC: present uop(cmd, step). If step is the last step and !stall, assert done and go to IDLE. Otherwise step++.
  - ABORT: instr=LRST for exactly one cycle, then IDLE.
- Return to IDLE drives instr=NOP. Minimum spacing between commands is therefore length+1 cycles.
- stall=1 in EXEC: instr=NOP, step holds, done=0. When stall drops, the same step is re-presented (no skip, no repeat). stall in IDLE: no accept.
- abort=1 in EXEC: the current micro-op is not issued. Next cycle goes to ABORT (LRST), done is never asserted. abort has priority over stall. abort in IDLE or ABORT is ignored.
- Simultaneous last-step completion and abort: abort wins, no done.
- step is 2 bits and never exceeds the command length minus 1. No wrap-around is reachable.

Decomposition:
- Package regfile_pkg:
  - MC_* command codes: NOP=0, LDA=1, LDB=2, LDOP=3, MOVAB=4, SWAP=5, CLR=6, LDAB=7.
  - UOP_* register-file encodings: NOP=4'h0, WA_IMM=4'h1, WB_IMM=4'h2, WOP_IMM=4'h3, A2B=4'h4, B2A=4'h5, A2OP=4'h6, OP2A=4'h7, B2OP=4'h8, OP2B=4'h9, LRST=4'hF.
  - FSM state typedef.
  - Per-command length constants.
- One sub-module: regfile_uop_rom, a combinational (cmd, step) -> micro-op lookup plus a last-step flag. The FSM and registers stay in the top.

Test Plan:
- Reset then MC_LDA, cmd_imm=4'hA -> next cycle instr=4'h1, imm=4'hA, done=1. Following cycle instr=0, cmd_ready=1. Register A reads back 4'hA.
- A=3, B=5, then MC_SWAP -> instr 4'h6, 4'h5, 4'h9 on consecutive cycles, done on the third. Afterwards A=5, B=3.
- MC_LDAB imm=4'h7 with stall=1 on the second step for 2 cycles -> instr 1, 0, 0, 2. done only with the WB_IMM cycle.
- MC_SWAP with abort on the second step -> instr 4'h6, then 4'hF, then 0. done never asserted. cmd_ready=1 one cycle after LRST.
- grst asserted mid-SWAP -> instr=0, busy=0, imm=0 immediately (asynchronous). After release, cmd_ready=1 and MC_NOP completes in 1 cycle with done=1.
- cmd_valid held high with back-to-back MC_LDB -> accepted every 2 cycles; no command lost or duplicated (count done pulses equal to handshakes).
